// File: rtl/przesuniecie_lewo_sekw.sv
// ---------------------------------------------------------------------------
// przesuniecie_lewo_sekw
// Sequential arithmetic left shift: the signed operand i_arg_A is shifted left
// by s = ~i_arg_B bits, one bit per clock. A negative s rejects the operation
// (o_error). o_overflow reports that the true shifted value does not fit in
// BITS signed bits.
//
// Handshake (start / busy / valid):
//   - i_start is sampled only while the unit is idle (o_busy=0, o_valid=0).
//     A start seen while busy or while the result is being presented is
//     dropped, not queued.
//   - o_busy is high from the accepting edge until the edge that produces the
//     result.
//   - o_valid is a single-cycle pulse. While it is high, o_result, o_error
//     and o_overflow describe the operation that just finished. Those three
//     outputs then hold their values until the next accepted start.
//   - o_dbg_state exposes the FSM state (0=IDLE, 1=SHIFT, 2=DONE).
// ---------------------------------------------------------------------------
module przesuniecie_lewo_sekw #(
  parameter int BITS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  output logic [BITS-1:0] o_result,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_error,
  output logic            o_overflow,
  output logic [1:0]      o_dbg_state
);

  localparam int CNT_W = $clog2(BITS + 1);

  // BITS as a BITS-wide vector, so the shift amount is compared at matching width.
  localparam logic [BITS-1:0] BITS_V  = BITS'(BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BITS-1:0]  shreg;
  logic [CNT_W-1:0] cnt;

  // Decoded shift amount for the operand currently on the bus.
  logic [BITS-1:0]  shamt;
  logic             shamt_neg;
  logic             shamt_big;
  logic [CNT_W-1:0] cnt_load;
  logic             accept;
  logic             cnt_zero;
  logic             sign_change;

  // Shift-amount decode: s = ~B as a signed value. Amounts of BITS or more
  // clear every bit anyway, so the counter is clamped to BITS.
  always_comb begin
    shamt     = ~i_arg_B;
    shamt_neg = shamt[BITS-1];
    shamt_big = (shamt >= BITS_V);
    cnt_load  = '0;
    if (shamt_big) begin
      cnt_load = CNT_MAX;
    end else begin
      cnt_load = shamt[CNT_W-1:0];
    end
  end

  // Control qualifiers shared by the FSM and the datapath.
  always_comb begin
    accept      = (state == IDLE) && i_start;
    cnt_zero    = (cnt == '0);
    // Shifting loses the sign whenever the two top bits differ.
    sign_change = shreg[BITS-1] ^ shreg[BITS-2];
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> SHIFT on accept, SHIFT -> DONE once the counter
  // reaches zero, DONE -> IDLE after one presentation cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_zero) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the state.
  always_comb begin
    o_valid     = (state == DONE);
    o_busy      = (state == SHIFT);
    o_dbg_state = state;
  end

  // Datapath: operand load on accept, one shift per SHIFT cycle, result
  // capture when the count is exhausted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg      <= '0;
      cnt        <= '0;
      o_result   <= '0;
      o_error    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            o_overflow <= 1'b0;
            if (shamt_neg) begin
              // Rejected: run an empty shift so the result reads as zero.
              o_error <= 1'b1;
              shreg   <= '0;
              cnt     <= '0;
            end else begin
              o_error <= 1'b0;
              shreg   <= i_arg_A;
              cnt     <= cnt_load;
            end
          end
        end
        SHIFT: begin
          if (!cnt_zero) begin
            if (sign_change) begin
              o_overflow <= 1'b1;
            end
            shreg <= {shreg[BITS-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
          end else begin
            o_result <= shreg;
          end
        end
        DONE: begin
          shreg <= shreg;
        end
        default: begin
          shreg <= shreg;
        end
      endcase
    end
  end

endmodule

// File: doc/przesuniecie_lewo_sekw.md
Name: przesuniecie_lewo_sekw

Overview:
- Sequential arithmetic left-shift unit, the counterpart of the team's combinational right-shift block.
- Shifts signed i_arg_A left by ~i_arg_B bits, one bit per clock.
- Start/busy/valid handshake; reports negative-shift error and signed overflow.
- Sits beside the other arithmetic sub-units in the synchronous arithmetic unit, driven by the same operand bus.

Parameters:
BITS, 32, operand/result width in bits (>= 4)
CNT_W, $clog2(BITS+1), localparam; width of the shift counter

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_start  input  1  request; sampled only when o_busy=0
i_arg_A  input  BITS  signed operand to shift
i_arg_B  input  BITS  signed; shift amount s = ~i_arg_B, interpreted as signed
o_result  output  BITS  signed shifted result; held until next accepted start
o_valid  output  1  one-cycle pulse; o_result/o_error/o_overflow are valid
o_busy  output  1  operation in progress
o_error  output  1  s < 0; the operation was rejected
o_overflow  output  1  true result not representable in BITS signed bits

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: o_result=0, o_valid=0, o_busy=0, o_error=0, o_overflow=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts it immediately. No o_valid is produced for the aborted operation.
- States: IDLE, SHIFT, DONE.
- IDLE, with i_start=1 at edge k (accept):
  - Latch A into the shift register.
  - Compute s = ~i_arg_B (signed).
  - If s < 0: o_error=1, register=0, counter=0.
  - If 0 <= s < BITS: counter=s.
  - If s >= BITS: counter=BITS (clamped).
  - Clear o_overflow; o_busy=1; go to SHIFT.
- SHIFT, each edge with counter > 0:
  - If reg[BITS-1] != reg[BITS-2] before the shift, set o_overflow (sticky).
  - reg <= reg << 1, shifting in 0; counter--.
- SHIFT, edge with counter == 0: o_result <= reg, o_valid=1, o_busy=0, go to DONE.
- DONE: o_valid returns to 0 at the next edge, go to IDLE.
- i_start is sampled in IDLE only. A start in DONE or SHIFT is ignored, not queued.
- Latency: o_valid is high during the cycle after edge k+1+n, where n=min(s,BITS) for s >= 0 and n=0 when o_error.
  - o_busy is high from edge k to edge k+1+n.
  - Back-to-back: the earliest next accept is at edge k+3+n.
- Boundary results:
  - s=0: o_result=A, o_overflow=0.
  - s>=BITS: o_result=0; o_overflow=1 iff A != 0.
  - Error: o_result=0, o_overflow=0.
- o_error and o_overflow hold their values until the next accepted start. They are never both 1.
- Width rules: only the low BITS bits are kept; no sign extension beyond BITS.

Test Plan (BITS=8):
- A=8'h05, B=8'hFC (s=3), start at edge k -> o_valid after edge k+4, o_result=8'h28, o_overflow=0, o_error=0; o_busy high 4 cycles.
- A=8'h40, B=8'hFE (s=1) -> o_result=8'h80, o_overflow=1; A=8'hFF, B=8'hF8 (s=7) -> o_result=8'h80, o_overflow=0.
- A=8'h12, B=8'hFF (s=0) -> o_valid after edge k+1, o_result=8'h12, no flags. A=8'h12, B=8'h01 (s=-2) -> o_error=1, o_result=0, o_valid after edge k+1.
- A=8'h01, B=8'hEB (s=20) -> 8 shift cycles, o_valid after edge k+9, o_result=0, o_overflow=1; repeat with A=0 -> o_overflow=0.
- i_start held high continuously with changing operands -> only the operand at each IDLE acceptance is used; accepts occur every n+3 edges; mid-operation starts are ignored.
- Assert i_rst_n=0 asynchronously during SHIFT -> all outputs 0 immediately, no o_valid. After release, a new start with A=8'h03, s=2 -> o_result=8'h0C.
